// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared definitions for the NES bus arbiter and decoder.
//   - ARB_MODE_FIXED / ARB_MODE_RR arbitration mode selectors
//   - arb_state_t  : arbiter FSM states (IDLE, OWN, HANDOFF)
//   - default NES CPU memory map (WRAM, PPU registers, PRG), packed with slave 0 in the LSBs
package nes_bus_pkg;

    localparam int unsigned ARB_MODE_FIXED = 0;
    localparam int unsigned ARB_MODE_RR    = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        HANDOFF = 2'd2
    } arb_state_t;

    localparam logic [15:0] WRAM_BASE = 16'h0000;
    localparam logic [15:0] WRAM_MASK = 16'hE000;
    localparam logic [15:0] PPU_BASE  = 16'h2000;
    localparam logic [15:0] PPU_MASK  = 16'hE000;
    localparam logic [15:0] PRG_BASE  = 16'h8000;
    localparam logic [15:0] PRG_MASK  = 16'h8000;

    localparam logic [47:0] CPU_MAP_BASE = {PRG_BASE, PPU_BASE, WRAM_BASE};
    localparam logic [47:0] CPU_MAP_MASK = {PRG_MASK, PPU_MASK, WRAM_MASK};

endpackage

// File: rtl/nes_bus_decode.sv
// nes_bus_decode: combinational base/mask address decoder.
// A slave region hits when (addr & mask) == base; the lowest-index hit wins,
// so the output is one-hot, or all zero for an unmapped address or when
// enable is low.
// Ports:
//   addr    in   ADDR_W      address to decode
//   enable  in   1           qualifies every enable output
//   en      out  NUM_SLAVES  one-hot slave enable
module nes_bus_decode
    import nes_bus_pkg::*;
#(
    parameter int unsigned                  NUM_SLAVES = 3,
    parameter int unsigned                  ADDR_W     = 16,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = CPU_MAP_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = CPU_MAP_MASK
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  enable,
    output logic [NUM_SLAVES-1:0] en
);

    logic hit;

    always_comb begin
        en  = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (enable && !hit &&
                ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                en[i] = 1'b1;
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nes_bus_arb.sv
// nes_bus_arb: multi-master bus arbiter and address decoder for the NES CPU
// bus (also usable for the PPU VRAM bus with a different map).
// One master owns the bus at a time (fixed priority, highest index wins, or
// round-robin); ownership is held while the owner requests, and a one-cycle
// HANDOFF with no enables separates consecutive owners. Read data returns one
// cycle after the access, selected by the registered slave enable.
// Optional feature (macro NES_BUS_ARB_TIMEOUT_EN): watchdog that revokes an
// owner after TIMEOUT_CYCLES of contention and pulses timeout_out.
// Ports:
//   clk_in, rst_in      clock, asynchronous active-high reset
//   m_req_in            per-master request
//   m_a_in / m_r_nw_in / m_d_in   packed master address / read(1)-write(0) / write data
//   m_gnt_out           registered one-hot owner
//   m_rdy_out           owner's bit high in OWN, all else stalled
//   m_d_out             read data shared by all masters
//   s_en_out            one-hot slave enable
//   s_a_out / s_r_nw_out / s_d_out   muxed owner address / r_nw / write data
//   s_d_in              packed slave read data
//   owner_out           index of current owner
//   timeout_out         watchdog revoke pulse (0 without the macro)
module nes_bus_arb
    import nes_bus_pkg::*;
#(
    parameter int unsigned                  NUM_MASTERS    = 2,
    parameter int unsigned                  NUM_SLAVES     = 3,
    parameter int unsigned                  ADDR_W         = 16,
    parameter int unsigned                  DATA_W         = 8,
    parameter int unsigned                  ARB_MODE       = ARB_MODE_FIXED,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE       = CPU_MAP_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK       = CPU_MAP_MASK,
    parameter int unsigned                  TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NUM_MASTERS-1:0]        m_req_in,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_a_in,
    input  logic [NUM_MASTERS-1:0]        m_r_nw_in,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_d_in,
    output logic [NUM_MASTERS-1:0]        m_gnt_out,
    output logic [NUM_MASTERS-1:0]        m_rdy_out,
    output logic [DATA_W-1:0]             m_d_out,
    output logic [NUM_SLAVES-1:0]         s_en_out,
    output logic [ADDR_W-1:0]             s_a_out,
    output logic                          s_r_nw_out,
    output logic [DATA_W-1:0]             s_d_out,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_d_in,
    output logic [2:0]                    owner_out,
    output logic                          timeout_out
);

    arb_state_t             state_q;
    logic [2:0]             owner_q;
    logic [2:0]             rr_ptr_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [NUM_SLAVES-1:0]  sel_q;

    logic [NUM_MASTERS-1:0] owner_oh;
    logic [NUM_MASTERS-1:0] req_eff;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [2:0]             win_idx;
    logic [2:0]             win_next_ptr;
    logic                   win_found;
    logic                   owner_req;
    logic                   bus_active;
    logic                   expired;
    int unsigned            rr_idx;

    logic [ADDR_W-1:0]      own_a;
    logic                   own_r_nw;
    logic [DATA_W-1:0]      own_d;

    assign bus_active = (state_q == OWN);
    assign owner_req  = |(m_req_in & owner_oh);

`ifdef NES_BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0]       to_cnt_q;
    logic [NUM_MASTERS-1:0] skip_q;
    logic                   to_pulse_q;
    logic                   contended;

    assign contended   = |(m_req_in & ~owner_oh);
    assign expired     = bus_active && contended && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign req_eff     = m_req_in & ~skip_q;
    assign timeout_out = to_pulse_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            to_cnt_q   <= '0;
            skip_q     <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_pulse_q <= expired;
            // Held at zero outside OWN so every new owner starts a fresh count.
            if (!bus_active || expired)
                to_cnt_q <= '0;
            else if (contended)
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            // The skip mask only applies to the arbitration that closes HANDOFF.
            if (expired)
                skip_q <= owner_oh;
            else if (state_q == HANDOFF)
                skip_q <= '0;
        end
    end
`else
    assign expired     = 1'b0;
    assign req_eff     = m_req_in;
    assign timeout_out = 1'b0;
`endif

    // Winner selection. Round-robin scans the rotated order backwards so the
    // last hit is the first requester at or after the pointer.
    always_comb begin
        win_found = |req_eff;
        win_idx   = '0;
        rr_idx    = 0;
        if (ARB_MODE == ARB_MODE_RR) begin
            for (int unsigned k = NUM_MASTERS; k > 0; k--) begin
                rr_idx = (32'(rr_ptr_q) + k - 1) % NUM_MASTERS;
                if (req_eff[rr_idx])
                    win_idx = 3'(rr_idx);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (req_eff[i])
                    win_idx = 3'(i);
            end
        end
        win_next_ptr = 3'((32'(win_idx) + 1) % NUM_MASTERS);
    end

    always_comb begin
        win_oh   = '0;
        owner_oh = '0;
        own_a    = '0;
        own_r_nw = 1'b1;
        own_d    = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            win_oh[i]   = (win_idx == 3'(i));
            owner_oh[i] = (owner_q == 3'(i));
            if (owner_q == 3'(i)) begin
                own_a    = m_a_in[i*ADDR_W +: ADDR_W];
                own_r_nw = m_r_nw_in[i];
                own_d    = m_d_in[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            sel_q    <= '0;
        end else begin
            sel_q <= s_en_out;
            case (state_q)
                IDLE, HANDOFF: begin
                    if (win_found) begin
                        state_q  <= OWN;
                        owner_q  <= win_idx;
                        gnt_q    <= win_oh;
                        rr_ptr_q <= win_next_ptr;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                    end
                end
                OWN: begin
                    if (!owner_req || expired) begin
                        state_q <= HANDOFF;
                        gnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign m_gnt_out  = gnt_q;
    assign m_rdy_out  = bus_active ? owner_oh : '0;
    assign owner_out  = owner_q;
    assign s_a_out    = bus_active ? own_a : '0;
    assign s_r_nw_out = bus_active ? own_r_nw : 1'b1;
    assign s_d_out    = bus_active ? own_d : '0;

    nes_bus_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .addr   (s_a_out),
        .enable (bus_active),
        .en     (s_en_out)
    );

    // The registered select gates each slave, so idle slaves may drive anything.
    always_comb begin
        m_d_out = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i])
                m_d_out = m_d_out | s_d_in[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_nes_bus_arb.sv
// tb_nes_bus_arb: directed self-checking bench for nes_bus_arb.
// dut    : 2 masters, fixed priority, default CPU map, TIMEOUT_CYCLES = 8
// dut_rr : 3 masters, round-robin
module tb_nes_bus_arb;

    logic        clk;
    logic        rst;

    logic [1:0]  req;
    logic [31:0] a;
    logic [1:0]  rnw;
    logic [15:0] d;
    logic [1:0]  gnt;
    logic [1:0]  rdy;
    logic [7:0]  md;
    logic [2:0]  sen;
    logic [15:0] sa;
    logic        srnw;
    logic [7:0]  sd;
    logic [23:0] sdin;
    logic [2:0]  owner;
    logic        tout;

    logic [2:0]  r_req;
    logic [47:0] r_a;
    logic [2:0]  r_rnw;
    logic [23:0] r_d;
    logic [2:0]  r_gnt;
    logic [2:0]  r_rdy;
    logic [7:0]  r_md;
    logic [2:0]  r_sen;
    logic [15:0] r_sa;
    logic        r_srnw;
    logic [7:0]  r_sd;
    logic [23:0] r_sdin;
    logic [2:0]  r_owner;
    logic        r_tout;

    int n_assert = 0;
    int n_fail   = 0;

    nes_bus_arb #(
        .NUM_MASTERS    (2),
        .ARB_MODE       (0),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .m_req_in    (req),
        .m_a_in      (a),
        .m_r_nw_in   (rnw),
        .m_d_in      (d),
        .m_gnt_out   (gnt),
        .m_rdy_out   (rdy),
        .m_d_out     (md),
        .s_en_out    (sen),
        .s_a_out     (sa),
        .s_r_nw_out  (srnw),
        .s_d_out     (sd),
        .s_d_in      (sdin),
        .owner_out   (owner),
        .timeout_out (tout)
    );

    nes_bus_arb #(
        .NUM_MASTERS (3),
        .ARB_MODE    (1)
    ) dut_rr (
        .clk_in      (clk),
        .rst_in      (rst),
        .m_req_in    (r_req),
        .m_a_in      (r_a),
        .m_r_nw_in   (r_rnw),
        .m_d_in      (r_d),
        .m_gnt_out   (r_gnt),
        .m_rdy_out   (r_rdy),
        .m_d_out     (r_md),
        .s_en_out    (r_sen),
        .s_a_out     (r_sa),
        .s_r_nw_out  (r_srnw),
        .s_d_out     (r_sd),
        .s_d_in      (r_sdin),
        .owner_out   (r_owner),
        .timeout_out (r_tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned exp_order[4] = '{0, 1, 2, 0};

    initial begin
        rst    = 1'b1;
        req    = 2'b00;
        a      = {16'h1234, 16'h0005};
        rnw    = 2'b11;
        d      = {8'h3F, 8'h55};
        sdin   = {8'hC2, 8'hB1, 8'hA0};
        r_req  = 3'b000;
        r_a    = '0;
        r_rnw  = 3'b111;
        r_d    = '0;
        r_sdin = {8'h33, 8'h22, 8'h11};
        #2;
        chk("rst_gnt",   32'(gnt),   0);
        chk("rst_rdy",   32'(rdy),   0);
        chk("rst_sen",   32'(sen),   0);
        chk("rst_srnw",  32'(srnw),  1);
        chk("rst_sa",    32'(sa),    0);
        chk("rst_sd",    32'(sd),    0);
        chk("rst_md",    32'(md),    0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_tout",  32'(tout),  0);
        chk("rst_rr_gnt", 32'(r_gnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // CPU read from WRAM
        req = 2'b01;
        #1;
        chk("req_gnt_not_yet", 32'(gnt), 0);
        tick();
        chk("m0_gnt",   32'(gnt),  32'h1);
        chk("m0_rdy",   32'(rdy),  32'h1);
        chk("m0_sen",   32'(sen),  32'h1);
        chk("m0_sa",    32'(sa),   32'h0005);
        chk("m0_srnw",  32'(srnw), 1);
        chk("m0_md_lat", 32'(md),  0);
        tick();
        chk("m0_md_wram", 32'(md), 32'hA0);

        // HCI requests while CPU owns: locked
        req = 2'b11;
        rnw = 2'b01;
        a   = {16'h2006, 16'h0005};
        tick();
        chk("lock_gnt1", 32'(gnt), 32'h1);
        tick();
        chk("lock_gnt2", 32'(gnt), 32'h1);
        chk("lock_rdy",  32'(rdy), 32'h1);
        chk("lock_tout", 32'(tout), 0);
        req = 2'b10;
        tick();
        chk("ho_gnt",  32'(gnt),  0);
        chk("ho_sen",  32'(sen),  0);
        chk("ho_srnw", 32'(srnw), 1);
        chk("ho_rdy",  32'(rdy),  0);
        tick();
        chk("m1_gnt",   32'(gnt),   32'h2);
        chk("m1_rdy",   32'(rdy),   32'h2);
        chk("m1_owner", 32'(owner), 1);
        chk("wr_sen",   32'(sen),   32'h2);
        chk("wr_srnw",  32'(srnw),  0);
        chk("wr_sd",    32'(sd),    32'h3F);
        chk("wr_sa",    32'(sa),    32'h2006);

        // unmapped, then PRG read
        a   = {16'h5000, 16'h0005};
        rnw = 2'b11;
        #1;
        chk("unmap_sen", 32'(sen), 0);
        tick();
        chk("unmap_md", 32'(md), 0);
        a = {16'h8123, 16'h0005};
        #1;
        chk("prg_sen", 32'(sen), 32'h4);
        tick();
        chk("prg_md", 32'(md), 32'hC2);

        // asynchronous reset in the middle of a write
        a   = {16'h2006, 16'h0005};
        rnw = 2'b01;
        #1;
        chk("pre_rst_sen",  32'(sen),  32'h2);
        chk("pre_rst_srnw", 32'(srnw), 0);
        #2;
        rst = 1'b1;
        req = 2'b00;
        #1;
        chk("arst_srnw",  32'(srnw),  1);
        chk("arst_sen",   32'(sen),   0);
        chk("arst_gnt",   32'(gnt),   0);
        chk("arst_rdy",   32'(rdy),   0);
        chk("arst_owner", 32'(owner), 0);
        chk("arst_sa",    32'(sa),    0);
        chk("arst_sd",    32'(sd),    0);
        chk("arst_md",    32'(md),    0);
        @(negedge clk);
        rst = 1'b0;
        rnw = 2'b11;
        tick();
        chk("post_rst_idle", 32'(gnt), 0);

        // same master releases and re-requests: HANDOFF still inserted
        req = 2'b01;
        tick();
        chk("rereq_own", 32'(gnt), 32'h1);
        req = 2'b00;
        tick();
        chk("rereq_ho", 32'(gnt), 0);
        req = 2'b01;
        tick();
        chk("rereq_again",  32'(gnt),   32'h1);
        chk("rereq_owner",  32'(owner), 0);

        // simultaneous requests from IDLE: highest index wins
        req = 2'b00;
        tick();
        tick();
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_rdy", 32'(rdy), 0);
        req = 2'b11;
        tick();
        chk("prio_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        tick();
        tick();

        // watchdog
        req = 2'b01;
        tick();
        chk("wd_own", 32'(gnt), 32'h1);
        req = 2'b11;
        repeat (7) tick();
        chk("wd_hold_gnt",  32'(gnt),  32'h1);
        chk("wd_hold_tout", 32'(tout), 0);
        tick();
`ifdef NES_BUS_ARB_TIMEOUT_EN
        chk("wd_revoke_gnt",  32'(gnt),  0);
        chk("wd_revoke_tout", 32'(tout), 1);
        tick();
        chk("wd_m1_gnt",  32'(gnt),  32'h2);
        chk("wd_m1_tout", 32'(tout), 0);
`else
        chk("wd_off_gnt",  32'(gnt),  32'h1);
        chk("wd_off_tout", 32'(tout), 0);
        tick();
        chk("wd_off_gnt2", 32'(gnt), 32'h1);
`endif
        req = 2'b00;
        tick();
        tick();

        // round-robin, 3 masters, each owner releases after 2 cycles
        r_req = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_gnt_%0d", i), 32'(r_gnt), 32'(1) << exp_order[i]);
            chk($sformatf("rr_rdy_%0d", i), 32'(r_rdy), 32'(1) << exp_order[i]);
            chk($sformatf("rr_own_%0d", i), 32'(r_owner), exp_order[i]);
            tick();
            chk($sformatf("rr_hold_%0d", i), 32'(r_gnt), 32'(1) << exp_order[i]);
            r_req = 3'b111;
            r_req[exp_order[i]] = 1'b0;
            tick();
            chk($sformatf("rr_ho_%0d", i), 32'(r_gnt), 0);
            chk($sformatf("rr_ho_rdy_%0d", i), 32'(r_rdy), 0);
            r_req = 3'b111;
            tick();
        end
        chk("rr_tout", 32'(r_tout), 0);
        r_req = 3'b000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
